clk_period_meter: RTL and testbench

Measures a slow, asynchronous square wave, such as a divided clock from clkdiv, against the system clock. It recovers the full period and the high time, both in system-clock cycles, and is the receive-side counterpart to the clock divider. Uses: self-checking of divider chains, frequency monitoring, and reading back externally generated clocks.

---
 rtl/clk_period_meter.sv | 144 ++++++++++++++
 tb/tb_clk_period_meter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow async square wave
// in clk cycles. Optional 4-sample period averaging via CLK_PERIOD_METER_AVG_EN.
//
// Ports:
//   clk     system clock
//   rst     asynchronous reset, active-high
//   in      measured square wave, asynchronous to clk
//   period  cycles between consecutive rising edges (averaged when enabled)
//   high    cycles from rising edge to following falling edge
//   valid   one-cycle strobe, period/high updated this cycle
//   timeout level, no rising edge within 2^WIDTH-1 cycles
module clk_period_meter #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high,
  output logic             valid,
  output logic             timeout
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;

  state_t                 state;
  logic [WIDTH-1:0]       cnt;
  logic [WIDTH-1:0]       hshadow;

  // cap: a rise closes a measurement window
  // sat: counter pinned at its maximum with no rise in sight
  logic                   cap;
  logic                   sat;
  logic                   cap_ok;
  logic [WIDTH-1:0]       cap_period;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
      s_d  <= s;
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  assign cap = (state == MEASURE) && rise;
  assign sat = (state == MEASURE) && !rise && (cnt == CMAX);

`ifdef CLK_PERIOD_METER_AVG_EN
  logic [WIDTH-1:0] hist [4];
  logic [WIDTH+1:0] sum;
  logic [WIDTH+1:0] sum_nx;
  logic [2:0]       ncap;

  // Running sum of the last four raw periods; the oldest drops out as the
  // newest enters, so no adder tree is needed.
  assign sum_nx     = sum + {2'b00, cnt} - {2'b00, hist[3]};
  assign cap_ok     = (ncap >= 3'd3);
  assign cap_period = sum_nx[WIDTH+1:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      sum  <= '0;
      ncap <= '0;
    end else if (sat) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      sum  <= '0;
      ncap <= '0;
    end else if (cap) begin
      hist[0] <= cnt;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hist[3] <= hist[2];
      sum     <= sum_nx;
      if (ncap != 3'd4) ncap <= ncap + 3'd1;
    end
  end
`else
  assign cap_ok     = 1'b1;
  assign cap_period = cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hshadow <= '0;
      period  <= '0;
      high    <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            cnt     <= ONE;
            hshadow <= '0;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (cap_ok) begin
              period  <= cap_period;
              high    <= hshadow;
              valid   <= 1'b1;
              timeout <= 1'b0;
            end
            cnt     <= ONE;
            hshadow <= '0;
          end else if (cnt == CMAX) begin
            timeout <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + ONE;
            if (fall) hshadow <= cnt;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed bench for clk_period_meter (WIDTH=8).
// A negedge-driven generator produces the square wave on in.
module tb_clk_period_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in  = 1'b0;
  logic [7:0] period;
  logic [7:0] high;
  logic       valid;
  logic       timeout;

  int pass  = 0;
  int total = 0;

  int gen_p   = 20;
  int gen_h   = 10;
  int ph      = 0;
  bit gen_en  = 1'b0;
  bit gen_avg = 1'b0;
  int plist[4] = '{10, 12, 14, 16};
  int pidx    = 0;

  clk_period_meter #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .period(period),
    .high(high),
    .valid(valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gen_en) begin
      in = (ph < gen_h);
      if (ph + 1 >= gen_p) begin
        ph = 0;
        if (gen_avg) begin
          pidx  = (pidx + 1) % 4;
          gen_p = plist[pidx];
        end
      end else begin
        ph = ph + 1;
      end
    end else begin
      in = 1'b0;
    end
  end

  task automatic wait_valid(input int budget, output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (valid) got = 1'b1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    total++; if (period !== 8'd0) $display("FAIL rst_period: got %0d want 0", period); else pass++;
    total++; if (high !== 8'd0) $display("FAIL rst_high: got %0d want 0", high); else pass++;
    total++; if (valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", valid); else pass++;
    total++; if (timeout !== 1'b0) $display("FAIL rst_timeout: got %0b want 0", timeout); else pass++;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_square;
    int n;
    bit got;
    @(posedge clk);
    gen_p = 20; gen_h = 10; ph = 0; gen_en = 1'b1;
    // first rise captured 3 edges in, second one 20 later: no valid before
    wait_valid(60, n, got);
    total++; if (!got || n != 23) $display("FAIL sq_first: got %0d want 23 (seen %0b)", n, got); else pass++;
    total++; if (period !== 8'd20) $display("FAIL sq_period0: got %0d want 20", period); else pass++;
    total++; if (high !== 8'd10) $display("FAIL sq_high0: got %0d want 10", high); else pass++;
    total++; if (timeout !== 1'b0) $display("FAIL sq_timeout0: got %0b want 0", timeout); else pass++;
    for (int i = 0; i < 6; i++) begin
      wait_valid(40, n, got);
      total++; if (!got || n != 20) $display("FAIL sq_gap: got %0d want 20", n); else pass++;
      total++; if (period !== 8'd20 || high !== 8'd10)
        $display("FAIL sq_vals: got %0d/%0d want 20/10", period, high); else pass++;
    end
  endtask

  task automatic test_switch;
    int n;
    bit got;
    @(posedge clk);
    gen_p = 30; gen_h = 9; ph = 0;
    repeat (2) wait_valid(60, n, got);
    for (int i = 0; i < 3; i++) begin
      wait_valid(60, n, got);
      total++; if (!got || n != 30) $display("FAIL sw30_gap: got %0d want 30", n); else pass++;
      total++; if (period !== 8'd30 || high !== 8'd9)
        $display("FAIL sw30_vals: got %0d/%0d want 30/9", period, high); else pass++;
    end
    @(posedge clk);
    gen_p = 8; gen_h = 4; ph = 0;
    wait_valid(60, n, got);
    for (int i = 0; i < 4; i++) begin
      wait_valid(30, n, got);
      total++; if (!got || n != 8) $display("FAIL sw8_gap: got %0d want 8", n); else pass++;
      total++; if (period !== 8'd8 || high !== 8'd4)
        $display("FAIL sw8_vals: got %0d/%0d want 8/4", period, high); else pass++;
    end
  endtask

  task automatic test_timeout;
    int n;
    bit got;
    int k;
    int first;
    int vcnt;
    @(posedge clk);
    gen_p = 16; gen_h = 8; ph = 0;
    repeat (2) wait_valid(60, n, got);
    wait_valid(40, n, got);
    total++; if (!got || period !== 8'd16 || high !== 8'd8)
      $display("FAIL to_pre: got %0d/%0d want 16/8", period, high); else pass++;
    // valid visible here means cnt=1; cnt reaches 255 after 254 more edges
    // and timeout registers on the edge after that
    gen_en = 1'b0;
    first = 0;
    vcnt  = 0;
    for (k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (valid) vcnt++;
      if (timeout && first == 0) first = k;
    end
    total++; if (first != 255) $display("FAIL to_when: got %0d want 255", first); else pass++;
    total++; if (vcnt != 0) $display("FAIL to_novalid: got %0d want 0", vcnt); else pass++;
    total++; if (timeout !== 1'b1) $display("FAIL to_level: got %0b want 1", timeout); else pass++;
    total++; if (period !== 8'd16 || high !== 8'd8)
      $display("FAIL to_hold: got %0d/%0d want 16/8", period, high); else pass++;
    @(posedge clk);
    gen_p = 16; gen_h = 8; ph = 0; gen_en = 1'b1;
    wait_valid(60, n, got);
    total++; if (!got || n != 19) $display("FAIL to_resume: got %0d want 19", n); else pass++;
    total++; if (timeout !== 1'b0) $display("FAIL to_clear: got %0b want 0", timeout); else pass++;
    total++; if (period !== 8'd16 || high !== 8'd8)
      $display("FAIL to_vals: got %0d/%0d want 16/8", period, high); else pass++;
  endtask

  task automatic test_reset_mid;
    int n;
    bit got;
    wait_valid(40, n, got);
    // pin is low from 6 edges after this valid until the next rise
    repeat (6) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if (period !== 8'd0 || high !== 8'd0 || valid !== 1'b0 || timeout !== 1'b0)
      $display("FAIL rm_clear: got %0d/%0d/%0b/%0b want 0/0/0/0", period, high, valid, timeout);
    else pass++;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    wait_valid(60, n, got);
    total++; if (!got || n < 17 || n > 36) $display("FAIL rm_first: got %0d want 17..36", n); else pass++;
    total++; if (period !== 8'd16 || high !== 8'd8)
      $display("FAIL rm_vals: got %0d/%0d want 16/8", period, high); else pass++;
  endtask

  task automatic test_avg;
    int n;
    bit got;
    @(posedge clk);
    gen_avg = 1'b1; pidx = 0; gen_p = 10; gen_h = 5; ph = 0; gen_en = 1'b1;
    // first rise at edge 3, valid on the fifth rise: 3 + 10+12+14+16
    wait_valid(120, n, got);
    total++; if (!got || n != 55) $display("FAIL avg_first: got %0d want 55", n); else pass++;
    total++; if (period !== 8'd13 || high !== 8'd5)
      $display("FAIL avg_vals0: got %0d/%0d want 13/5", period, high); else pass++;
    for (int i = 0; i < 5; i++) begin
      wait_valid(40, n, got);
      total++; if (!got || period !== 8'd13 || high !== 8'd5)
        $display("FAIL avg_vals: got %0d/%0d want 13/5", period, high); else pass++;
    end
  endtask

  initial begin
    test_reset();
`ifdef CLK_PERIOD_METER_AVG_EN
    test_avg();
`else
    test_square();
    test_switch();
    test_timeout();
    test_reset_mid();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
